// File: rtl/dds_sweep_ctrl_if.sv
// Key-pulse inputs and DDS configuration outputs of the sweep controller.
// The master side is the key_filter bank plus the DDS datapath reading the config.
interface dds_sweep_ctrl_if #(
    parameter int unsigned FW_W = 32
);
    logic            key_wave;
    logic            key_mode;
    logic            key_run;
    logic [1:0]      wave_c;
    logic [1:0]      mode;
    logic [FW_W-1:0] freq_word;
    logic            phase_clr;
    logic            busy;
    logic            done;

    modport master (
        output key_wave, key_mode, key_run,
        input  wave_c, mode, freq_word, phase_clr, busy, done
    );

    modport slave (
        input  key_wave, key_mode, key_run,
        output wave_c, mode, freq_word, phase_clr, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS control block: fixed-frequency or stepped sweep (single-shot / looping)
// from F_START to F_STOP, each word held DWELL+1 cycles.
module dds_sweep_ctrl #(
    parameter int unsigned     FW_W    = 32,
    parameter int unsigned     DWELL_W = 24,
    parameter logic [FW_W-1:0] F_START = FW_W'(1000),
    parameter logic [FW_W-1:0] F_STOP  = FW_W'(8000),
    parameter logic [FW_W-1:0] F_STEP  = FW_W'(1000),
    parameter int unsigned     DWELL   = 50000
) (
    input logic             clk,
    input logic             rst,
    dds_sweep_ctrl_if.slave bus
);

    if (F_START > F_STOP || F_STEP == '0 || DWELL == 0 ||
        64'(DWELL) >= (64'd1 << DWELL_W)) begin : g_bad_params
        $error("dds_sweep_ctrl: illegal F_START/F_STOP/F_STEP/DWELL");
    end

    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_STEP,
        S_DONE
    } state_t;

    state_t               state;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [1:0]           wave_c;
    logic [1:0]           mode;
    logic [FW_W-1:0]      freq_word;
    logic                 phase_clr;
    logic                 busy;
    logic                 done;

    // One extra bit so a step past the top of the word range can never wrap small.
    logic [FW_W:0]        nxt;
    assign nxt = {1'b0, freq_word} + {1'b0, F_STEP};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            wave_c    <= 2'd0;
            mode      <= 2'd0;
            freq_word <= F_START;
            phase_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            phase_clr <= 1'b0;
            done      <= 1'b0;

            if (bus.key_wave) begin
                wave_c <= wave_c + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.key_run) begin
                        phase_clr <= 1'b1;
                        freq_word <= F_START;
                        if (mode != 2'd0) begin
                            dwell_cnt <= DWELL_RELOAD;
                            busy      <= 1'b1;
                            state     <= S_DWELL;
                        end
                    end else if (bus.key_mode) begin
                        mode <= (mode == 2'd2) ? 2'd0 : mode + 2'd1;
                    end
                end

                S_DWELL: begin
                    if (bus.key_run) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (dwell_cnt == '0) begin
                        state <= S_STEP;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end

                S_STEP: begin
                    if (bus.key_run) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (nxt <= {1'b0, F_STOP}) begin
                        freq_word <= nxt[FW_W-1:0];
                        dwell_cnt <= DWELL_RELOAD;
                        state     <= S_DWELL;
                    end else if (mode == 2'd2) begin
                        freq_word <= F_START;
                        phase_clr <= 1'b1;
                        dwell_cnt <= DWELL_RELOAD;
                        state     <= S_DWELL;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wave_c    = wave_c;
    assign bus.mode      = mode;
    assign bus.freq_word = freq_word;
    assign bus.phase_clr = phase_clr;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: two instances (small sweep, top-of-range sweep)
// driven by the same keys and compared each cycle against an arithmetic model.
module tb_dds_sweep_ctrl;

    logic clk;
    logic rst;
    logic key_wave;
    logic key_mode;
    logic key_run;
    bit   chk_en;

    int n_checks;
    int n_errors;

    dds_sweep_ctrl_if #(.FW_W(32)) bus0 ();
    dds_sweep_ctrl_if #(.FW_W(32)) bus1 ();

    assign bus0.key_wave = key_wave;
    assign bus0.key_mode = key_mode;
    assign bus0.key_run  = key_run;
    assign bus1.key_wave = key_wave;
    assign bus1.key_mode = key_mode;
    assign bus1.key_run  = key_run;

    dds_sweep_ctrl #(
        .FW_W(32), .DWELL_W(24),
        .F_START(32'd10), .F_STOP(32'd40), .F_STEP(32'd10), .DWELL(3)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    dds_sweep_ctrl #(
        .FW_W(32), .DWELL_W(24),
        .F_START(32'hFFFF_FFFB), .F_STOP(32'hFFFF_FFFF), .F_STEP(32'd3), .DWELL(3)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a sweep is described only by the cycles elapsed since key_run.
    longint m_f0   [2] = '{64'd10, 64'hFFFF_FFFB};
    longint m_f1   [2] = '{64'd40, 64'hFFFF_FFFF};
    longint m_fs   [2] = '{64'd10, 64'd3};
    int     m_per  = 4;
    int     m_n    [2];
    logic [1:0] m_wave [2];
    logic [1:0] m_mode [2];
    longint     m_freq [2];
    bit         m_pc   [2];
    bit         m_busy [2];
    bit         m_done [2];
    bit         m_act  [2];
    int         m_e    [2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k]    = int'((m_f1[k] - m_f0[k]) / m_fs[k]) + 1;
            m_wave[k] = 2'd0;
            m_mode[k] = 2'd0;
            m_freq[k] = m_f0[k];
            m_pc[k]   = 1'b0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_act[k]  = 1'b0;
            m_e[k]    = 0;
        end
    endtask

    task automatic model_step(input bit kw, input bit km, input bit kr);
        int  span;
        bit  in_sweep;
        for (int k = 0; k < 2; k++) begin
            span     = m_n[k] * m_per;
            m_pc[k]   = 1'b0;
            m_done[k] = 1'b0;
            if (kw) m_wave[k] = m_wave[k] + 2'd1;
            if (m_act[k]) begin
                in_sweep = (m_mode[k] == 2'd2) || (m_e[k] <= span);
                if (kr && in_sweep) begin
                    m_act[k]  = 1'b0;
                    m_busy[k] = 1'b0;
                end else begin
                    m_e[k]++;
                    if (m_mode[k] == 2'd2) begin
                        m_freq[k] = m_f0[k] + longint'(((m_e[k] - 1) / m_per) % m_n[k]) * m_fs[k];
                        m_pc[k]   = ((m_e[k] - 1) % span) == 0;
                    end else if (m_e[k] <= span) begin
                        m_freq[k] = m_f0[k] + longint'((m_e[k] - 1) / m_per) * m_fs[k];
                    end else if (m_e[k] == span + 1) begin
                        m_done[k] = 1'b1;
                        m_busy[k] = 1'b0;
                    end else begin
                        m_act[k] = 1'b0;
                    end
                end
            end else if (kr) begin
                m_pc[k]   = 1'b1;
                m_freq[k] = m_f0[k];
                if (m_mode[k] != 2'd0) begin
                    m_act[k]  = 1'b1;
                    m_busy[k] = 1'b1;
                    m_e[k]    = 1;
                end
            end else if (km) begin
                m_mode[k] = (m_mode[k] == 2'd2) ? 2'd0 : m_mode[k] + 2'd1;
            end
        end
    endtask

    task automatic compareInst(input int k, input logic [1:0] w, input logic [1:0] md,
                               input logic [31:0] f, input logic pc, input logic b, input logic d);
        checkOutput($sformatf("i%0d wave_c", k),    64'(w),  64'(m_wave[k]));
        checkOutput($sformatf("i%0d mode", k),      64'(md), 64'(m_mode[k]));
        checkOutput($sformatf("i%0d freq_word", k), 64'(f),  m_freq[k]);
        checkOutput($sformatf("i%0d phase_clr", k), 64'(pc), 64'(m_pc[k]));
        checkOutput($sformatf("i%0d busy", k),      64'(b),  64'(m_busy[k]));
        checkOutput($sformatf("i%0d done", k),      64'(d),  64'(m_done[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compareInst(0, bus0.wave_c, bus0.mode, bus0.freq_word, bus0.phase_clr, bus0.busy, bus0.done);
            compareInst(1, bus1.wave_c, bus1.mode, bus1.freq_word, bus1.phase_clr, bus1.busy, bus1.done);
        end
    end

    // One clock cycle: keys set after the falling edge, model advanced on the rising edge.
    task automatic applyStimulus(input bit kw, input bit km, input bit kr);
        @(negedge clk);
        key_wave = kw;
        key_mode = km;
        key_run  = kr;
        @(posedge clk);
        if (!rst) model_step(kw, km, kr);
    endtask

    task automatic doReset();
        @(negedge clk);
        key_wave = 1'b0;
        key_mode = 1'b0;
        key_run  = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput("async rst freq_word", 64'(bus0.freq_word), 64'd10);
        checkOutput("async rst busy",      64'(bus0.busy),      64'd0);
        checkOutput("async rst wave_c",    64'(bus0.wave_c),    64'd0);
        checkOutput("async rst mode",      64'(bus0.mode),      64'd0);
        checkOutput("async rst i1 freq",   64'(bus1.freq_word), 64'hFFFF_FFFB);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        key_wave = 1'b0;
        key_mode = 1'b0;
        key_run  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        checkOutput("reset freq_word", 64'(bus0.freq_word), 64'd10);
        checkOutput("reset i1 freq",   64'(bus1.freq_word), 64'hFFFF_FFFB);
        checkOutput("reset busy",      64'(bus0.busy),      64'd0);

        // Fixed mode: single phase_clr, never busy.
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("fixed phase_clr", 64'(bus0.phase_clr), 64'd1);
        checkOutput("fixed busy",      64'(bus0.busy),      64'd0);
        checkOutput("fixed freq_word", 64'(bus0.freq_word), 64'd10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fixed pulse end", 64'(bus0.phase_clr), 64'd0);

        // Single-shot sweep.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 19; j++) begin
            #1;
            case (j)
                1: begin
                    checkOutput("once t+1 phase_clr", 64'(bus0.phase_clr), 64'd1);
                    checkOutput("once t+1 freq",      64'(bus0.freq_word), 64'd10);
                    checkOutput("once i1 t+1 freq",   64'(bus1.freq_word), 64'hFFFF_FFFB);
                end
                4:  checkOutput("once t+4 freq",  64'(bus0.freq_word), 64'd10);
                5: begin
                    checkOutput("once t+5 freq",  64'(bus0.freq_word), 64'd20);
                    checkOutput("once i1 t+5 freq", 64'(bus1.freq_word), 64'hFFFF_FFFE);
                end
                9:  checkOutput("once i1 done",   64'(bus1.done),      64'd1);
                10: checkOutput("once i1 no wrap", 64'(bus1.freq_word), 64'hFFFF_FFFE);
                16: checkOutput("once t+16 busy", 64'(bus0.busy),      64'd1);
                17: begin
                    checkOutput("once t+17 done", 64'(bus0.done),      64'd1);
                    checkOutput("once t+17 busy", 64'(bus0.busy),      64'd0);
                    checkOutput("once t+17 freq", 64'(bus0.freq_word), 64'd40);
                end
                18: checkOutput("once t+18 done", 64'(bus0.done),      64'd0);
                default: ;
            endcase
            applyStimulus(1'b0, 1'b0, 1'b0);
        end

        // Looping sweep started together with key_mode; key_mode also pressed mid-sweep.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int j = 1; j <= 53; j++) begin
            #1;
            case (j)
                1:  checkOutput("loop run+mode mode", 64'(bus0.mode),      64'd2);
                4:  checkOutput("loop busy mode",     64'(bus0.mode),      64'd2);
                17: begin
                    checkOutput("loop wrap freq",     64'(bus0.freq_word), 64'd10);
                    checkOutput("loop wrap clr",      64'(bus0.phase_clr), 64'd1);
                end
                49: checkOutput("loop 3rd wrap clr",  64'(bus0.phase_clr), 64'd1);
                default: ;
            endcase
            applyStimulus(1'b0, j == 3, j == 53);
        end
        #1;
        checkOutput("abort freq held", 64'(bus0.freq_word), 64'd20);
        checkOutput("abort busy",      64'(bus0.busy),      64'd0);
        checkOutput("abort i1 freq",   64'(bus1.freq_word), 64'hFFFF_FFFE);

        // Five waveform steps.
        for (int i = 0; i < 5; i++) begin
            logic [1:0] wexp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            applyStimulus(1'b1, 1'b0, 1'b0);
            #1;
            checkOutput("wave step", 64'(bus0.wave_c), 64'(wexp[i]));
        end

        // Reset in the middle of a looping sweep.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
        doReset();

        // Random key traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 7) == 0,
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 24) == 0);
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
